// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types, constants and helpers for the cache controller
// Purpose: request opcodes, controller FSM states, replacement policy selectors
//          and the saturating increment used by the statistics counters.
package cache_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_INVAL = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam int REPL_TRUE_LRU = 0;
    localparam int REPL_MRU1     = 1;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
        return (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
    endfunction

endpackage

// File: rtl/cache_repl.sv
// rtl/cache_repl.sv - per-set replacement state and victim selection
// Purpose: holds true-LRU ages and 1-bit MRU flags for every set, picks the
//          victim way for the selected set and applies touch/invalidate updates.
// Ports:   clk, rst      - clock, synchronous active-high reset
//          set_i         - set being looked up / updated
//          valid_i       - valid bits of that set (invalid ways are filled first)
//          touch_i       - mark way_i as most recently used
//          inval_i       - way_i was invalidated (clears its MRU flag only)
//          way_i         - way being touched or invalidated
//          victim_o      - way to fill on a miss
module cache_repl
    import cache_pkg::*;
#(
    parameter int NUM_SETS    = 32,
    parameter int NUM_WAYS    = 8,
    parameter int REPL_POLICY = REPL_TRUE_LRU,
    localparam int IDX_W = $clog2(NUM_SETS),
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    set_i,
    input  logic [NUM_WAYS-1:0] valid_i,
    input  logic                touch_i,
    input  logic                inval_i,
    input  logic [WAY_W-1:0]    way_i,
    output logic [WAY_W-1:0]    victim_o
);

    logic [WAY_W-1:0]    age_q [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] mru_q [NUM_SETS];

    logic [WAY_W-1:0]    lru_victim;
    logic [WAY_W-1:0]    mru_victim;
    logic [WAY_W-1:0]    inv_way;
    logic                inv_found;
    logic [NUM_WAYS-1:0] mru_touch;

    // Scanning from the top way down leaves the lowest matching index selected.
    always_comb begin
        inv_found  = 1'b0;
        inv_way    = '0;
        lru_victim = '0;
        mru_victim = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_i[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (!mru_q[set_i][w]) begin
                mru_victim = WAY_W'(w);
            end
            if (age_q[set_i][w] == WAY_W'(NUM_WAYS - 1)) begin
                lru_victim = WAY_W'(w);
            end
        end
        if (NUM_WAYS == 1) begin
            victim_o = '0;
        end else if (inv_found) begin
            victim_o = inv_way;
        end else if (REPL_POLICY == REPL_MRU1) begin
            victim_o = mru_victim;
        end else begin
            victim_o = lru_victim;
        end
    end

    // Setting the last clear flag would leave no victim, so restart the epoch
    // with only the touched way marked.
    always_comb begin
        mru_touch = mru_q[set_i] | (NUM_WAYS'(1) << way_i);
        if (&mru_touch) begin
            mru_touch = NUM_WAYS'(1) << way_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                mru_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else if (touch_i) begin
            // Ages stay a permutation: only ways younger than the touched one age.
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_W'(w) == way_i) begin
                    age_q[set_i][w] <= '0;
                end else if (age_q[set_i][w] < age_q[set_i][way_i]) begin
                    age_q[set_i][w] <= age_q[set_i][w] + 1'b1;
                end
            end
            mru_q[set_i] <= mru_touch;
        end else if (inval_i) begin
            mru_q[set_i][way_i] <= 1'b0;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - set-associative cache tag/state controller with statistics
// Purpose: accepts one read/write/invalidate request at a time, looks up the tag
//          array, allocates on misses, and reports hit/evict/writeback per request.
// Ports:   clk, rst             - clock, synchronous active-high reset
//          req_valid/req_ready  - request handshake (ready only while idle)
//          req_op, req_addr     - opcode and byte address {tag, index, offset}
//          rsp_*                - one-cycle registered response
//          stats_clr, stat_*    - counter clear and saturating statistics
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int NUM_SETS    = 32,
    parameter int NUM_WAYS    = 8,
    parameter int LINE_SIZE   = 64,
    parameter int REPL_POLICY = REPL_TRUE_LRU,
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_addr,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic             rsp_evict,
    output logic             rsp_writeback,
    output logic [WAY_W-1:0] rsp_way,
    input  logic             stats_clr,
    output logic [31:0]      stat_reads,
    output logic [31:0]      stat_writes,
    output logic [31:0]      stat_hits,
    output logic [31:0]      stat_misses,
    output logic [31:0]      stat_evictions,
    output logic [31:0]      stat_writebacks,
    output logic [31:0]      stat_invalidates
);

    localparam int OFF_W = $clog2(LINE_SIZE);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 32 - OFF_W - IDX_W;

    state_e           state_q;
    op_e              op_q;
    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] idx_q;

    logic             rsp_valid_q;
    logic             rsp_hit_q;
    logic             rsp_evict_q;
    logic             rsp_wb_q;
    logic [WAY_W-1:0] rsp_way_q;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [TAG_W-1:0]    tags_q  [NUM_SETS][NUM_WAYS];

    logic [31:0] stat_reads_q, stat_writes_q, stat_hits_q, stat_misses_q;
    logic [31:0] stat_evictions_q, stat_writebacks_q, stat_invalidates_q;

    logic             lk_hit;
    logic [WAY_W-1:0] lk_hit_way;
    logic [WAY_W-1:0] victim;
    logic             rw_d;
    logic             hit_d;
    logic             evict_d;
    logic             wb_d;
    logic             fill_d;
    logic             inval_d;
    logic [WAY_W-1:0] way_d;
    logic             upd;

    // Line offset never affects tag state.
    logic unused_offset;
    assign unused_offset = ^req_addr[OFF_W-1:0];

    assign upd = (state_q == ST_LOOKUP);

    always_comb begin
        lk_hit     = 1'b0;
        lk_hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx_q][w] && (tags_q[idx_q][w] == tag_q)) begin
                lk_hit     = 1'b1;
                lk_hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        rw_d    = 1'b0;
        hit_d   = 1'b0;
        evict_d = 1'b0;
        wb_d    = 1'b0;
        fill_d  = 1'b0;
        inval_d = 1'b0;
        way_d   = '0;
        case (op_q)
            OP_READ, OP_WRITE: begin
                rw_d    = 1'b1;
                hit_d   = lk_hit;
                fill_d  = !lk_hit;
                way_d   = lk_hit ? lk_hit_way : victim;
                evict_d = !lk_hit && valid_q[idx_q][victim];
                wb_d    = !lk_hit && valid_q[idx_q][victim] && dirty_q[idx_q][victim];
            end
            OP_INVAL: begin
                if (lk_hit) begin
                    hit_d   = 1'b1;
                    inval_d = 1'b1;
                    way_d   = lk_hit_way;
                    wb_d    = dirty_q[idx_q][lk_hit_way];
                end
            end
            default: begin
            end
        endcase
    end

    cache_repl #(
        .NUM_SETS    (NUM_SETS),
        .NUM_WAYS    (NUM_WAYS),
        .REPL_POLICY (REPL_POLICY)
    ) u_repl (
        .clk      (clk),
        .rst      (rst),
        .set_i    (idx_q),
        .valid_i  (valid_q[idx_q]),
        .touch_i  (upd && rw_d),
        .inval_i  (upd && inval_d),
        .way_i    (way_d),
        .victim_o (victim)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_READ;
            tag_q       <= '0;
            idx_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_evict_q <= 1'b0;
            rsp_wb_q    <= 1'b0;
            rsp_way_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= op_e'(req_op);
                        tag_q   <= req_addr[31 -: TAG_W];
                        idx_q   <= req_addr[OFF_W +: IDX_W];
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_hit_q   <= hit_d;
                    rsp_evict_q <= evict_d;
                    rsp_wb_q    <= wb_d;
                    rsp_way_q   <= way_d;
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_hit_q   <= 1'b0;
                    rsp_evict_q <= 1'b0;
                    rsp_wb_q    <= 1'b0;
                    rsp_way_q   <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    tags_q[s][w] <= '0;
                end
            end
        end else if (upd) begin
            if (fill_d) begin
                valid_q[idx_q][way_d] <= 1'b1;
                dirty_q[idx_q][way_d] <= (op_q == OP_WRITE);
                tags_q[idx_q][way_d]  <= tag_q;
            end else if (rw_d && (op_q == OP_WRITE)) begin
                dirty_q[idx_q][way_d] <= 1'b1;
            end else if (inval_d) begin
                valid_q[idx_q][way_d] <= 1'b0;
                dirty_q[idx_q][way_d] <= 1'b0;
            end
        end
    end

    // A clear in the same cycle as an update discards that update.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            stat_reads_q       <= '0;
            stat_writes_q      <= '0;
            stat_hits_q        <= '0;
            stat_misses_q      <= '0;
            stat_evictions_q   <= '0;
            stat_writebacks_q  <= '0;
            stat_invalidates_q <= '0;
        end else if (upd) begin
            stat_reads_q       <= sat_inc(stat_reads_q, op_q == OP_READ);
            stat_writes_q      <= sat_inc(stat_writes_q, op_q == OP_WRITE);
            stat_hits_q        <= sat_inc(stat_hits_q, rw_d && hit_d);
            stat_misses_q      <= sat_inc(stat_misses_q, rw_d && !hit_d);
            stat_evictions_q   <= sat_inc(stat_evictions_q, evict_d);
            stat_writebacks_q  <= sat_inc(stat_writebacks_q, wb_d);
            stat_invalidates_q <= sat_inc(stat_invalidates_q, op_q == OP_INVAL);
        end
    end

    assign req_ready        = (state_q == ST_IDLE) && !rst;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_hit          = rsp_hit_q;
    assign rsp_evict        = rsp_evict_q;
    assign rsp_writeback    = rsp_wb_q;
    assign rsp_way          = rsp_way_q;
    assign stat_reads       = stat_reads_q;
    assign stat_writes      = stat_writes_q;
    assign stat_hits        = stat_hits_q;
    assign stat_misses      = stat_misses_q;
    assign stat_evictions   = stat_evictions_q;
    assign stat_writebacks  = stat_writebacks_q;
    assign stat_invalidates = stat_invalidates_q;

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter NUM_SETS, default 32: sets; power of 2, 2..4096.
REQ-002 Parameter NUM_WAYS, default 8: associativity; power of 2, 1..16.
REQ-003 Parameter LINE_SIZE, default 64: line bytes; power of 2, 32..128.
REQ-004 Parameter REPL_POLICY, default 0: 0 = true LRU, 1 = 1-bit MRU pseudo-LRU.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  controller idle, can accept.
REQ-009 req_op  in  2  0 read, 1 write, 2 invalidate, 3 reserved.
REQ-010 req_addr  in  32  byte address, split {tag, index, offset}.
REQ-011 rsp_valid  out  1  one-cycle response pulse.
REQ-012 rsp_hit  out  1  tag matched a valid way.
REQ-013 rsp_evict  out  1  valid victim replaced.
REQ-014 rsp_writeback  out  1  dirty line written back (eviction or invalidate).
REQ-015 rsp_way  out  max(1,clog2(NUM_WAYS))  way hit, filled or invalidated.
REQ-016 stats_clr  in  1  zero all stat counters.
REQ-017 stat_reads, stat_writes, stat_hits, stat_misses, stat_evictions, stat_writebacks, stat_invalidates  out  32 each  saturating counters.

Function
REQ-018 Offset = clog2(LINE_SIZE) bits, index = clog2(NUM_SETS) bits, tag = remaining bits of 32.
REQ-019 FSM IDLE -> LOOKUP -> RESP -> IDLE; request accepted on edge with req_valid && req_ready in IDLE; req_ready = 1 only in IDLE.
REQ-020 Op/address captured at accept; req_valid in LOOKUP/RESP ignored; one request per 3 cycles max.
REQ-021 Tag compare in LOOKUP; arrays, replacement state and counters update on LOOKUP->RESP edge; rsp_valid high exactly during RESP.
REQ-022 Response fields registered; all rsp_* = 0 when rsp_valid = 0.
REQ-023 Read hit: update replacement, rsp_hit=1. Write hit: also set dirty.
REQ-024 Read/write miss: write-allocate into victim; dirty = (op==write); rsp_evict=1 if victim was valid; rsp_writeback=1 if victim was valid and dirty.
REQ-025 Victim: lowest-index invalid way; if none, policy victim.
REQ-026 True LRU: per-way age, clog2(NUM_WAYS) bits, 0 = MRU; on touch, ages below touched way's age increment, touched way -> 0; victim = way with age NUM_WAYS-1.
REQ-027 1-bit MRU: on touch set mru[w]; if all bits would be 1, clear all but w; victim = lowest-index way with mru=0.
REQ-028 Invalidate: if valid tag match, clear valid/dirty/mru, rsp_hit=1, rsp_writeback=dirty; replacement ages unchanged; miss = no state change.
REQ-029 Op 3: no state change, rsp_valid with all fields 0, no counters.
REQ-030 Counters: reads/writes per op; hits/misses for reads and writes only; invalidates for every op 2; evictions/writebacks per rsp flag; hold at 0xFFFFFFFF.
REQ-031 stats_clr zeroes counters next edge; wins over same-cycle increment; no effect on cache state or FSM.
REQ-032 NUM_WAYS=1: victim is always way 0, replacement state unused.

Reset
REQ-033 rst high: FSM -> IDLE, req_ready=0 during rst, 1 on first cycle after release; rsp_* = 0.
REQ-034 All valid/dirty/mru = 0, tags = 0, LRU age[w] = w, all counters 0.
REQ-035 rst mid-transaction aborts it: no rsp_valid, no counter or array update; rst has priority over stats_clr.

Structure
REQ-036 Package cache_pkg holds op enum (OP_READ, OP_WRITE, OP_INVAL, OP_RSVD), FSM state enum, REPL_TRUE_LRU/REPL_MRU1 constants.
REQ-037 Sub-module cache_repl: per-set replacement state, victim select, touch update, both policies, selected by REPL_POLICY.

Verification (defaults unless stated; set-1 addresses A(k) = 0x40 + k*0x800)
REQ-038 Reset; read A(0) -> miss, rsp_way=0, evict=0; read A(0) -> hit, way 0; stat_hits=1, stat_misses=1, stat_reads=2.
REQ-039 LRU: write A(0)..A(7), then read A(8) -> miss, evict=1, writeback=1, rsp_way=0; stat_evictions=1, stat_writebacks=1.
REQ-040 REPL_POLICY=1: read A(0)..A(7); read A(8) -> rsp_way=0, evict=1, writeback=0; read A(9) -> rsp_way=1.
REQ-041 Write A(0), invalidate A(0) -> hit=1, writeback=1, stat_invalidates=1; read A(0) -> miss, way 0, evict=0.
REQ-042 Hold req_valid 5 cycles: two accepts, rsp_valid 2 cycles after each accept; rst in LOOKUP -> no rsp_valid, counters 0, req_ready=1 after release.
REQ-043 stats_clr in RESP of a read miss -> all counters 0 next cycle; line still present (next read A(0) hits).
